regset_move_seq: RTL and testbench
==================================

// Module: regset_move_seq
//
// PURPOSE
// Bus-side sequencer for the 4x16-bit register set: accepts queued register
// commands (move, load-immediate, read-out) through a valid/ready port and
// generates the register set's control lines (writeSel, we, outSel, noe)
// plus, for immediates, drives the shared 16-bit bus itself.
// Guarantees that at most one driver is on io_bus in any cycle.
//
// PARAMETERS
// FIFO_DEPTH  4   command FIFO entries (power of 2, >=2)
//
// PORTS
// i_clk        in     1   clock
// i_reset      in     1   synchronous reset, active-high
// i_cmdValid   in     1   command offered
// o_cmdReady   out    1   FIFO not full; push on i_cmdValid & o_cmdReady
// i_cmdOp      in     2   00 MOV src->dst, 01 LDI imm->dst, 10 RD src, 11 NOP
// i_cmdSrc     in     2   source register index (MOV, RD)
// i_cmdDst     in     2   destination register index (MOV, LDI)
// i_cmdImm     in     16  immediate value (LDI)
// io_bus       inout  16  shared data bus; driven only in LDI DRIVE/COMMIT
// o_writeSel   out    2   to register set write select
// o_we         out    1   to register set write enable (capture at posedge)
// o_outSel     out    2   to register set output select
// o_noe        out    1   to register set bus driver enable, active-low
// o_rdData     out    16  last RD result
// o_rdValid    out    1   one-cycle pulse: o_rdData updated
// o_busy       out    1   FSM not IDLE or FIFO not empty
//
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, o_noe=1, o_we=0, o_writeSel=0, o_outSel=0,
//   io_bus hi-Z, o_rdData=0, o_rdValid=0, o_cmdReady=1, o_busy=0.
// - All control outputs registered. FIFO: push/pop same cycle allowed when
//   not full; no bypass (pushed cmd poppable next cycle at earliest).
// - FSM IDLE -> DRIVE (pop when FIFO non-empty) -> COMMIT -> GAP -> IDLE.
//   One op per 4 cycles incl. IDLE; NOP pops and returns IDLE (no DRIVE).
// - DRIVE:  MOV/RD: o_noe=0, o_outSel=src. LDI: o_noe=1, io_bus=imm. o_we=0.
// - COMMIT: same bus source as DRIVE; MOV/LDI: o_we=1, o_writeSel=dst, so
//   register set captures at the posedge ending COMMIT. RD: o_we=0, o_rdData
//   <= io_bus at that posedge, o_rdValid=1 in the following (GAP) cycle.
// - GAP: o_noe=1, o_we=0, io_bus hi-Z (bus turnaround; never two drivers).
// - MOV with src==dst is legal: register rewritten with its own value.
// - o_writeSel/o_outSel hold last value outside their active states.
// - Reset mid-op (any state): abort immediately, no write, FIFO flushed.
// - Invariant: io_bus driven => o_noe=1; o_we=1 only in COMMIT.
//
// TESTING
// 1 reset, LDI imm=16'h1234 dst=2 -> o_we high exactly 1 cycle, 4 cycles
//   after push, writeSel=2, bus=1234; reg2==1234 after, others 16'hFFFF.
// 2 LDI r1=16'hA5A5, MOV src=1 dst=3, RD src=3 -> o_rdData=A5A5, o_rdValid
//   one-cycle pulse; io_bus never driven while o_noe=0.
// 3 push 6 cmds back-to-back with FIFO_DEPTH=4 -> o_cmdReady low after 4
//   (5 if a pop occurred), all 6 executed in order, none lost/duplicated.
// 4 i_reset asserted during COMMIT of LDI r0=16'h0000 -> r0 stays FFFF,
//   outputs at reset values next cycle, queued cmds discarded.
// 5 MOV src=0 dst=0 and NOP -> r0 unchanged, NOP produces no o_we/o_noe=0.
// 6 random cmd stream vs. reference register model -> RD values match.

Source files
------------

// File: rtl/regset_move_seq.sv
// Command sequencer for the 4x16 register set: queues MOV/LDI/RD/NOP commands and walks
// each one through IDLE -> DRIVE -> COMMIT -> GAP, driving io_bus itself only for immediates.
module regset_move_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmdValid,
    output logic        o_cmdReady,
    input  logic [1:0]  i_cmdOp,
    input  logic [1:0]  i_cmdSrc,
    input  logic [1:0]  i_cmdDst,
    input  logic [15:0] i_cmdImm,
    inout  wire  [15:0] io_bus,
    output logic [1:0]  o_writeSel,
    output logic        o_we,
    output logic [1:0]  o_outSel,
    output logic        o_noe,
    output logic [15:0] o_rdData,
    output logic        o_rdValid,
    output logic        o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 22;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_COMMIT, S_GAP} state_t;

    // Command queue: pointers carry one extra bit so full and empty are distinguishable.
    logic [CW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [CW-1:0] head;
    logic [1:0]    head_op;
    logic [1:0]    head_src;
    logic [1:0]    head_dst;
    logic [15:0]   head_imm;

    state_t        state_reg;
    logic [1:0]    op_reg;
    logic [1:0]    dst_reg;
    logic [15:0]   imm_reg;
    logic [1:0]    write_sel_reg;
    logic [1:0]    out_sel_reg;
    logic          we_reg;
    logic          noe_reg;
    logic          bus_oe_reg;
    logic [15:0]   rd_data_reg;
    logic          rd_valid_reg;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign push       = i_cmdValid && !fifo_full;
    assign pop        = (state_reg == S_IDLE) && !fifo_empty;

    assign head = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign {head_op, head_src, head_dst, head_imm} = head;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {i_cmdOp, i_cmdSrc, i_cmdDst, i_cmdImm};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            state_reg     <= S_IDLE;
            op_reg        <= OP_NOP;
            dst_reg       <= 2'd0;
            imm_reg       <= 16'h0000;
            write_sel_reg <= 2'd0;
            out_sel_reg   <= 2'd0;
            we_reg        <= 1'b0;
            noe_reg       <= 1'b1;
            bus_oe_reg    <= 1'b0;
            rd_data_reg   <= 16'h0000;
            rd_valid_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        op_reg     <= head_op;
                        dst_reg    <= head_dst;
                        imm_reg    <= head_imm;
                        // NOP is consumed here and never leaves IDLE.
                        if (head_op != OP_NOP) begin
                            state_reg <= S_DRIVE;
                            if (head_op == OP_LDI) begin
                                bus_oe_reg <= 1'b1;
                            end else begin
                                noe_reg     <= 1'b0;
                                out_sel_reg <= head_src;
                            end
                        end
                    end
                end
                S_DRIVE: begin
                    state_reg <= S_COMMIT;
                    if (op_reg != OP_RD) begin
                        we_reg        <= 1'b1;
                        write_sel_reg <= dst_reg;
                    end
                end
                S_COMMIT: begin
                    // Release the bus together with the write so GAP is a clean turnaround.
                    state_reg  <= S_GAP;
                    we_reg     <= 1'b0;
                    noe_reg    <= 1'b1;
                    bus_oe_reg <= 1'b0;
                    if (op_reg == OP_RD) begin
                        rd_data_reg  <= io_bus;
                        rd_valid_reg <= 1'b1;
                    end
                end
                S_GAP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus = bus_oe_reg ? imm_reg : 16'hzzzz;

    // A reset arriving during COMMIT must kill the write at the very edge it ends on,
    // so the registered enable is qualified with the live reset.
    assign o_we       = we_reg && !i_reset;
    assign o_writeSel = write_sel_reg;
    assign o_outSel   = out_sel_reg;
    assign o_noe      = noe_reg;
    assign o_rdData   = rd_data_reg;
    assign o_rdValid  = rd_valid_reg;
    assign o_cmdReady = !fifo_full;
    assign o_busy     = (state_reg != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_regset_move_seq.sv
// Bench for regset_move_seq: a behavioural 4x16 register set on io_bus, a table of directed
// commands with hand-computed results, plus burst, reset-abort and random-stream sequences.
module tb_regset_move_seq;
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [15:0] imm;
        logic [15:0] exp_rd;
        logic [15:0] exp_reg;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmdValid;
    logic        o_cmdReady;
    logic [1:0]  i_cmdOp;
    logic [1:0]  i_cmdSrc;
    logic [1:0]  i_cmdDst;
    logic [15:0] i_cmdImm;
    wire  [15:0] io_bus;
    logic [1:0]  o_writeSel;
    logic        o_we;
    logic [1:0]  o_outSel;
    logic        o_noe;
    logic [15:0] o_rdData;
    logic        o_rdValid;
    logic        o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 i_clk = ~i_clk;

    regset_move_seq #(.FIFO_DEPTH(4)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cmdValid (i_cmdValid),
        .o_cmdReady (o_cmdReady),
        .i_cmdOp    (i_cmdOp),
        .i_cmdSrc   (i_cmdSrc),
        .i_cmdDst   (i_cmdDst),
        .i_cmdImm   (i_cmdImm),
        .io_bus     (io_bus),
        .o_writeSel (o_writeSel),
        .o_we       (o_we),
        .o_outSel   (o_outSel),
        .o_noe      (o_noe),
        .o_rdData   (o_rdData),
        .o_rdValid  (o_rdValid),
        .o_busy     (o_busy)
    );

    // Register set: powers up as all ones, drives the bus when noe is low.
    logic [15:0] rf [4];
    logic        rf_clear;
    assign io_bus = o_noe ? 16'hzzzz : rf[o_outSel];

    always @(posedge i_clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf[i] <= 16'hFFFF;
        end else if (o_we) begin
            rf[o_writeSel] <= io_bus;
        end
    end

    int we_cnt = 0;
    int rdv_cnt = 0;
    int noe_cnt = 0;
    int bus_bad = 0;
    logic [15:0] rd_q [$];
    logic [1:0]  ws_q [$];

    always @(negedge i_clk) begin
        if (o_we) begin
            we_cnt <= we_cnt + 1;
            ws_q.push_back(o_writeSel);
        end
        if (o_rdValid) begin
            rdv_cnt <= rdv_cnt + 1;
            rd_q.push_back(o_rdData);
        end
        if (!o_noe) noe_cnt <= noe_cnt + 1;
        if (!o_noe && io_bus !== rf[o_outSel]) bus_bad <= bus_bad + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input vec_t v);
        i_cmdOp  = v.op;
        i_cmdSrc = v.src;
        i_cmdDst = v.dst;
        i_cmdImm = v.imm;
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        rf_clear   = 1'b1;
        i_cmdValid = 1'b0;
        i_cmdOp    = OP_NOP;
        i_cmdSrc   = 2'd0;
        i_cmdDst   = 2'd0;
        i_cmdImm   = 16'h0000;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset  = 1'b0;
        rf_clear = 1'b0;
    endtask

    // Issue one command into an idle sequencer and check everything it should do.
    task automatic run_vec(input vec_t v, input int idx);
        int we0, rdv0, noe0, we_at, k;
        logic [1:0]  ws;
        logic [15:0] busv;
        logic [1:0]  reg_idx;
        logic        writes;
        we0 = we_cnt; rdv0 = rdv_cnt; noe0 = noe_cnt;
        we_at = -1; ws = 2'd0; busv = 16'h0000;
        @(posedge i_clk); #1;
        set_cmd(v);
        i_cmdValid = 1'b1;
        @(posedge i_clk); #1;
        i_cmdValid = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_we && we_at < 0) begin
                we_at = k;
                ws    = o_writeSel;
                busv  = io_bus;
            end
            if (!o_busy) break;
        end
        #1;
        chk("cmd_done", 32'(k <= 20), 32'd1);
        writes = (v.op == OP_MOV) || (v.op == OP_LDI);
        chk("we_pulses", we_cnt - we0, writes ? 32'd1 : 32'd0);
        if (writes) begin
            chk("we_timing", we_at, 32'd3);
            chk("write_sel", ws, v.dst);
            if (v.op == OP_LDI) chk("ldi_bus", busv, v.imm);
        end
        chk("noe_cycles", noe_cnt - noe0, (v.op == OP_MOV || v.op == OP_RD) ? 32'd2 : 32'd0);
        chk("rdvalid_pulses", rdv_cnt - rdv0, (v.op == OP_RD) ? 32'd1 : 32'd0);
        if (v.op == OP_RD) chk("rd_data", o_rdData, v.exp_rd);
        reg_idx = writes ? v.dst : v.src;
        chk("reg_value", rf[reg_idx], v.exp_reg);
        $display("[TB] cmd %0d op=%0d src=%0d dst=%0d imm=%h rd=%h r%0d=%h",
                 idx, v.op, v.src, v.dst, v.imm, o_rdData, reg_idx, rf[reg_idx]);
    endtask

    vec_t        vecs [13];
    vec_t        burst [6];
    logic [15:0] mdl [4];

    initial begin
        int idx, first_block, we0, c;
        logic acc;
        vec_t rv;

        vecs[0]  = '{OP_LDI, 2'd0, 2'd2, 16'h1234, 16'h0000, 16'h1234};
        vecs[1]  = '{OP_RD,  2'd0, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[2]  = '{OP_RD,  2'd3, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[3]  = '{OP_LDI, 2'd0, 2'd1, 16'hA5A5, 16'h0000, 16'hA5A5};
        vecs[4]  = '{OP_MOV, 2'd1, 2'd3, 16'h0000, 16'h0000, 16'hA5A5};
        vecs[5]  = '{OP_RD,  2'd3, 2'd0, 16'h0000, 16'hA5A5, 16'hA5A5};
        vecs[6]  = '{OP_MOV, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[7]  = '{OP_NOP, 2'd0, 2'd0, 16'hBEEF, 16'h0000, 16'hFFFF};
        vecs[8]  = '{OP_RD,  2'd2, 2'd0, 16'h0000, 16'h1234, 16'h1234};
        vecs[9]  = '{OP_LDI, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{OP_MOV, 2'd0, 2'd2, 16'h0000, 16'h0000, 16'h0000};
        vecs[11] = '{OP_RD,  2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[12] = '{OP_RD,  2'd1, 2'd0, 16'h0000, 16'hA5A5, 16'hA5A5};

        burst[0] = '{OP_LDI, 2'd0, 2'd0, 16'h1111, 16'h0000, 16'h0000};
        burst[1] = '{OP_LDI, 2'd0, 2'd1, 16'h2222, 16'h0000, 16'h0000};
        burst[2] = '{OP_LDI, 2'd0, 2'd2, 16'h3333, 16'h0000, 16'h0000};
        burst[3] = '{OP_MOV, 2'd2, 2'd3, 16'h0000, 16'h0000, 16'h0000};
        burst[4] = '{OP_RD,  2'd3, 2'd0, 16'h0000, 16'h0000, 16'h0000};
        burst[5] = '{OP_RD,  2'd1, 2'd0, 16'h0000, 16'h0000, 16'h0000};

        // Reset values.
        do_reset();
        @(negedge i_clk);
        chk("rst_noe", o_noe, 32'd1);
        chk("rst_we", o_we, 32'd0);
        chk("rst_write_sel", o_writeSel, 32'd0);
        chk("rst_out_sel", o_outSel, 32'd0);
        chk("rst_rd_data", o_rdData, 32'd0);
        chk("rst_rd_valid", o_rdValid, 32'd0);
        chk("rst_cmd_ready", o_cmdReady, 32'd1);
        chk("rst_busy", o_busy, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Back-to-back burst of six into a four-deep queue.
        do_reset();
        rd_q.delete();
        ws_q.delete();
        we0 = we_cnt;
        idx = 0;
        first_block = -1;
        set_cmd(burst[0]);
        i_cmdValid = 1'b1;
        for (c = 0; c < 200 && idx < 6; c++) begin
            @(negedge i_clk);
            acc = o_cmdReady;
            if (!acc && first_block < 0) first_block = idx;
            @(posedge i_clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) set_cmd(burst[idx]);
                else i_cmdValid = 1'b0;
            end
        end
        i_cmdValid = 1'b0;
        chk("burst_all_pushed", idx, 32'd6);
        chk("burst_ready_low_after", first_block, 32'd5);
        for (c = 0; c < 80; c++) begin
            @(negedge i_clk);
            if (!o_busy) break;
        end
        #1;
        chk("burst_drained", 32'(c < 80), 32'd1);
        chk("burst_we_pulses", we_cnt - we0, 32'd4);
        chk("burst_ws_count", ws_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < ws_q.size(); i++) chk("burst_ws_order", ws_q[i], 32'(i));
        chk("burst_rd_count", rd_q.size(), 32'd2);
        if (rd_q.size() >= 2) begin
            chk("burst_rd0", rd_q[0], 32'h3333);
            chk("burst_rd1", rd_q[1], 32'h2222);
        end
        chk("burst_r0", rf[0], 32'h1111);
        chk("burst_r3", rf[3], 32'h3333);
        $display("[TB] burst: pushed %0d, ready dropped after %0d, %0d reads", idx, first_block, rd_q.size());

        // Reset during COMMIT of LDI r0=0000 with two more commands queued.
        do_reset();
        we0 = we_cnt;
        @(posedge i_clk); #1;
        set_cmd('{OP_LDI, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000});
        i_cmdValid = 1'b1;
        @(posedge i_clk); #1;
        set_cmd('{OP_LDI, 2'd0, 2'd1, 16'h0F0F, 16'h0000, 16'h0000});
        @(posedge i_clk); #1;
        set_cmd('{OP_LDI, 2'd0, 2'd2, 16'h0F0F, 16'h0000, 16'h0000});
        @(posedge i_clk); #1;
        i_cmdValid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("abort_we_gated", o_we, 32'd0);
        chk("abort_commit_noe", o_noe, 32'd1);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("abort_noe", o_noe, 32'd1);
        chk("abort_we", o_we, 32'd0);
        chk("abort_write_sel", o_writeSel, 32'd0);
        chk("abort_out_sel", o_outSel, 32'd0);
        chk("abort_ready", o_cmdReady, 32'd1);
        chk("abort_busy", o_busy, 32'd0);
        repeat (12) @(negedge i_clk);
        #1;
        chk("abort_no_writes", we_cnt - we0, 32'd0);
        chk("abort_r0", rf[0], 32'hFFFF);
        chk("abort_r1", rf[1], 32'hFFFF);
        chk("abort_r2", rf[2], 32'hFFFF);
        chk("abort_idle", o_busy, 32'd0);
        $display("[TB] reset-abort: r0=%h r1=%h r2=%h", rf[0], rf[1], rf[2]);

        // Random command stream against a command-level register model.
        do_reset();
        for (int i = 0; i < 4; i++) mdl[i] = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            rv.op  = 2'($urandom_range(0, 3));
            rv.src = 2'($urandom_range(0, 3));
            rv.dst = 2'($urandom_range(0, 3));
            rv.imm = 16'($urandom);
            rv.exp_rd = mdl[rv.src];
            case (rv.op)
                OP_LDI:  mdl[rv.dst] = rv.imm;
                OP_MOV:  mdl[rv.dst] = mdl[rv.src];
                default: ;
            endcase
            rv.exp_reg = (rv.op == OP_LDI || rv.op == OP_MOV) ? mdl[rv.dst] : mdl[rv.src];
            run_vec(rv, 100 + i);
        end

        chk("bus_contention", bus_bad, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
